// File: rtl/mem_interface.sv
// Memory-side stage of the multicycle MIPS datapath: runs a req/ack transaction to
// variable-latency memory, owns IR and MDR, and stalls the Controller via MemBusy.
module mem_interface #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              lorD,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] B,
    output logic              MemBusy,
    output logic [DATA_W-1:0] Instr,
    output logic [DATA_W-1:0] MDR,
    output logic              BusErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic                ir_sel_q, ir_sel_d;
    logic                bus_err_q, bus_err_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                start;

    assign start = MemRead | MemWrite;

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        mdr_d     = mdr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        req_d     = req_q;
        we_d      = we_q;
        ir_sel_d  = ir_sel_q;
        bus_err_d = bus_err_q;
        cnt_d     = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d   = lorD ? ALUOut : PC;
                    wdata_d  = B;
                    we_d     = MemWrite;
                    // A simultaneous read+write is treated as a write, so the IR stays put
                    ir_sel_d = IRWrite & ~MemWrite;
                    req_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (mem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                        if (ir_sel_q) begin
                            instr_d = mem_rdata;
                        end
                    end
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    bus_err_d = 1'b1;
                    req_d     = 1'b0;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            instr_q   <= '0;
            mdr_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            ir_sel_q  <= 1'b0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            mdr_q     <= mdr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            req_q     <= req_d;
            we_q      <= we_d;
            ir_sel_q  <= ir_sel_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign MemBusy   = (state_q == StReq) | ((state_q == StIdle) & start);
    assign Instr     = instr_q;
    assign MDR       = mdr_q;
    assign BusErr    = bus_err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface: stimulus pushes expected transactions, a negedge
// monitor checks request attributes during REQ and results when mem_req drops.
module tb_mem_interface;

    localparam int unsigned TO = 4;

    logic        Clk = 1'b0;
    logic        Reset, MemRead, MemWrite, lorD, IRWrite;
    logic [31:0] PC, ALUOut, B;
    logic        MemBusy, BusErr, mem_req, mem_we, mem_ack;
    logic [31:0] Instr, MDR, mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] instr;
        logic [31:0] mdr;
        logic        bus_err;
        int          busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   skip_mon = 1'b0;
    bit   prev_req = 1'b0;
    int   busy_cnt = 0;

    always #5 Clk = ~Clk;

    mem_interface #(
        .DATA_W (32),
        .ADDR_W (32),
        .TIMEOUT(TO)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .lorD     (lorD),
        .IRWrite  (IRWrite),
        .PC       (PC),
        .ALUOut   (ALUOut),
        .B        (B),
        .MemBusy  (MemBusy),
        .Instr    (Instr),
        .MDR      (MDR),
        .BusErr   (BusErr),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks held request attributes each REQ cycle, results when mem_req falls
    always @(negedge Clk) begin
        if (Reset || skip_mon) begin
            busy_cnt = 0;
        end else begin
            if (MemBusy) busy_cnt++;
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", 32'(mem_req), 32'd0);
                end else begin
                    chk("mem_addr", mem_addr, exp_q[0].addr);
                    chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                    chk("mem_we", 32'(mem_we), 32'(exp_q[0].we));
                end
            end
            if (prev_req && !mem_req && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("Instr", Instr, e.instr);
                chk("MDR", MDR, e.mdr);
                chk("BusErr", 32'(BusErr), 32'(e.bus_err));
                chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
                chk("busy_in_done", 32'(MemBusy), 32'd0);
                busy_cnt = 0;
            end
        end
        prev_req = mem_req;
    end

    // Called one time unit after a posedge with the DUT in IDLE; returns likewise
    task automatic txn(input logic rd, input logic wr, input logic sel, input logic irw,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] b,
                       input int ack_cycle, input logic [31:0] rdata, input exp_t e);
        exp_q.push_back(e);
        MemRead = rd; MemWrite = wr; lorD = sel; IRWrite = irw;
        PC = pc; ALUOut = alu; B = b;
        @(posedge Clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == ack_cycle) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end
            @(posedge Clk); #1;
            mem_ack = 1'b0;
            mem_rdata = 32'hBADBAD00;
            if (!mem_req) break;
            if (k == 40) chk("txn_bound", 32'(mem_req), 32'd0);
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        Reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; lorD = 1'b0; IRWrite = 1'b0;
        PC = '0; ALUOut = '0; B = '0; mem_ack = 1'b0; mem_rdata = 32'hBADBAD00;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        chk("rst_Instr", Instr, 32'h0);
        chk("rst_MDR", MDR, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_BusErr", 32'(BusErr), 32'd0);
        chk("rst_MemBusy", 32'(MemBusy), 32'd0);
        @(posedge Clk); #1;

        // Fetch, ack on 2nd REQ cycle
        txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'h999, 32'h11111111, 2, 32'h8C220010,
            '{addr: 32'h4, wdata: 32'h11111111, we: 1'b0, instr: 32'h8C220010,
              mdr: 32'h8C220010, bus_err: 1'b0, busy: 3});
        // Load via ALUOut, IR untouched
        txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h100, 32'h0, 1, 32'hDEADBEEF,
            '{addr: 32'h100, wdata: 32'h0, we: 1'b0, instr: 32'h8C220010,
              mdr: 32'hDEADBEEF, bus_err: 1'b0, busy: 2});
        // Store, ack data must be ignored
        txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h200, 32'h12345678, 3, 32'hFFFFFFFF,
            '{addr: 32'h200, wdata: 32'h12345678, we: 1'b1, instr: 32'h8C220010,
              mdr: 32'hDEADBEEF, bus_err: 1'b0, busy: 4});
        // Timeout: no ack, abort after TO REQ cycles
        txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 0, 32'h0,
            '{addr: 32'h40, wdata: 32'h0, we: 1'b0, instr: 32'h8C220010,
              mdr: 32'hDEADBEEF, bus_err: 1'b1, busy: 1 + TO});
        // Fetch after timeout still completes, BusErr stays sticky
        txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 32'h0, 1, 32'h20010005,
            '{addr: 32'h44, wdata: 32'h0, we: 1'b0, instr: 32'h20010005,
              mdr: 32'h20010005, bus_err: 1'b1, busy: 2});

        // Reset on 2nd REQ cycle, late ack afterwards
        skip_mon = 1'b1;
        MemRead = 1'b1; IRWrite = 1'b1; lorD = 1'b0; PC = 32'h48;
        @(posedge Clk); #1;
        MemRead = 1'b0; IRWrite = 1'b0;
        @(posedge Clk); #1;
        chk("rst_mid_req_pre", 32'(mem_req), 32'd1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        @(posedge Clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'hBADBAD00;
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_Instr", Instr, 32'h0);
        chk("late_ack_MDR", MDR, 32'h0);
        chk("late_ack_BusErr", 32'(BusErr), 32'd0);
        chk("late_ack_busy", 32'(MemBusy), 32'd0);
        skip_mon = 1'b0;
        @(posedge Clk); #1;

        // Read and write together: write wins, IR not loaded
        txn(1'b1, 1'b1, 1'b1, 1'b1, 32'h4, 32'h300, 32'hA5A5A5A5, 1, 32'h77777777,
            '{addr: 32'h300, wdata: 32'hA5A5A5A5, we: 1'b1, instr: 32'h0,
              mdr: 32'h0, bus_err: 1'b0, busy: 2});

        repeat (3) @(posedge Clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
